if_id_skid: RTL and testbench
=============================

Name: if_id_skid

Overview:
- Next-generation IF/ID pipeline register for the LC-3b pipeline.
- Replaces the plain load-enable register with a valid/ready elastic stage. A 2-entry skid buffer lets fetch keep pushing for one cycle after decode stalls, with no combinational ready path.
- Carries PC, IR and the branch-predictor metadata: taken flag, 2-bit counter, local and global history indices.
- Adds a synchronous flush for mispredict recovery.

Parameters:
- W, 16, width of pc and ir words.
- LS, 8, local predictor index width.
- GS, 6, global history index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  stage can accept; registered.
- pc_in  in  W  fetch PC.
- ir_in  in  W  fetched instruction.
- br_pr_in  in  1  predicted-taken flag.
- pred_in  in  2  predictor counter value.
- local_index_in  in  LS  local table index.
- global_index_in  in  GS  global history index.
- out_valid  out  1  decode word valid.
- out_ready  in  1  decode accepts.
- pc_out  out  W  head PC.
- ir_out  out  W  head IR.
- br_pr_out  out  1  head taken flag.
- pred_out  out  2  head counter.
- local_index_out  out  LS  head local index.
- global_index_out  out  GS  head global index.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage:
  - Main entry drives all *_out ports directly from registers.
  - Skid entry sits behind the main entry, with its own valid bit.
- Reset (reset=0, asynchronous):
  - out_valid=0, skid valid=0, occupancy=0, in_ready=1.
  - All payload outputs = 0; skid payload = 0.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- States by occupancy: EMPTY(0), ONE(1), FULL(2).
- EMPTY:
  - push → input to main; go to ONE.
  - No push → stay EMPTY.
- ONE:
  - push & pop → input to main; stay ONE.
  - push & !pop → input to skid; go to FULL.
  - pop & !push → go to EMPTY.
  - Neither → hold.
- FULL (in_ready=0, so push is impossible):
  - pop → skid moves to main, skid invalid; go to ONE.
  - No pop → hold.
- in_ready is registered:
  - Equals !(next occupancy==2).
  - Deasserts in the cycle after the skid fills.
  - Reasserts in the cycle after a pop from FULL.
- Latency and throughput:
  - A push into EMPTY appears on the outputs the next cycle (1-cycle latency).
  - Sustained throughput is 1 word/cycle while out_ready=1.
- Ordering is strictly FIFO; no word is duplicated or lost except by flush.
- Payload fields travel together as one atomic word; no field is ever mixed between entries.
- flush=1 at a rising edge:
  - out_valid=0, skid invalid, occupancy=0, in_ready=1.
  - Main payload cleared to 0 (ir_out=0 is the NOP bubble); skid payload cleared to 0.
  - Flush has priority over push and pop in the same cycle: the input word is dropped and no pop is counted.
- out_ready while out_valid=0 has no effect.
- Data stability: while out_valid=1 and out_ready=0, every *_out signal holds its value.
- Reset asserted mid-operation:
  - Immediately returns to the reset state regardless of the clock.
  - Deassertion is assumed synchronised externally; the stage resumes from EMPTY on the first edge after release.
- occupancy always equals out_valid + skid valid.
  - Occupancy 2 occurs only with out_valid=1.

Test Plan:
- Reset/idle: drive reset=0 mid-cycle with occupancy=2 → out_valid=0, occupancy=0, in_ready=1, pc_out=0, ir_out=0 immediately, before the next edge.
- Streaming: out_ready=1; push pc 0x0000,0x0002,0x0004 on consecutive cycles → pc_out shows each value 1 cycle later; out_valid stays high 3 cycles; in_ready never drops.
- Stall/skid:
  - Push A(pc=0x10, ir=0x1234, pred=2'b11), then B(pc=0x12) with out_ready=0 → occupancy=2 and in_ready=0 the following cycle; pc_out holds 0x10.
  - Raise out_ready → A then B popped on consecutive cycles; in_ready=1 after the first pop.
- Flush priority: occupancy=2, assert flush with in_valid=1 (pc=0x40) and out_ready=1 → next cycle out_valid=0, occupancy=0, ir_out=0; 0x40 never appears.
- Metadata integrity:
  - LS=8, GS=6; push local_index=0xA5, global_index=0x2A, br_pr=1 while a stall forces the word through the skid entry.
  - → Outputs show exactly 0xA5/0x2A/1 together with the matching pc.
- Parameter sweep: W=32, LS=10, GS=12; random valid/ready for 10k cycles against a FIFO scoreboard → zero ordering or payload mismatches; occupancy never exceeds 2.

Source files
------------

// File: rtl/if_id_skid.sv
// if_id_skid -- IF/ID pipeline register for the LC-3b pipeline, built as a
// valid/ready elastic stage with a 2-entry skid buffer.
//
// Fetch may keep pushing for one cycle after decode stalls. in_ready is a
// flop, so no combinational path runs from out_ready to in_ready.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous reset, active low
//   flush               synchronous kill of all held entries (beats push/pop)
//   in_valid/in_ready   fetch-side handshake (in_ready registered)
//   pc_in, ir_in        fetch PC and instruction word (W bits)
//   br_pr_in, pred_in   predicted-taken flag, 2-bit predictor counter
//   local_index_in      local predictor table index (LS bits)
//   global_index_in     global history index (GS bits)
//   out_valid/out_ready decode-side handshake
//   *_out               head-entry payload, driven straight from registers
//   occupancy           number of entries held (0..2)
module if_id_skid #(
  parameter int unsigned W  = 16,
  parameter int unsigned LS = 8,
  parameter int unsigned GS = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  pc_in,
  input  logic [W-1:0]  ir_in,
  input  logic          br_pr_in,
  input  logic [1:0]    pred_in,
  input  logic [LS-1:0] local_index_in,
  input  logic [GS-1:0] global_index_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  pc_out,
  output logic [W-1:0]  ir_out,
  output logic          br_pr_out,
  output logic [1:0]    pred_out,
  output logic [LS-1:0] local_index_out,
  output logic [GS-1:0] global_index_out,
  output logic [1:0]    occupancy
);

  // One fetch word; every field moves as a unit between entries.
  typedef struct packed {
    logic [W-1:0]  pc;
    logic [W-1:0]  ir;
    logic          br_pr;
    logic [1:0]    pred;
    logic [LS-1:0] local_index;
    logic [GS-1:0] global_index;
  } word_t;

  // Encoding equals the number of held entries, so occupancy is the state flop.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  word_t  main_q, main_d;
  word_t  skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  word_t  in_word;
  logic   push, pop;

  assign in_word = {pc_in, ir_in, br_pr_in, pred_in, local_index_in, global_index_in};

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush wins: any input word this cycle is dropped and nothing pops.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = in_word;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_word;
          end else if (push) begin
            skid_d  = in_word;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    // Registered ready: look at the next occupancy so fetch stops right
    // after the skid entry fills and resumes right after it drains.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = (state_q != EMPTY);
  assign occupancy        = state_q;
  assign pc_out           = main_q.pc;
  assign ir_out           = main_q.ir;
  assign br_pr_out        = main_q.br_pr;
  assign pred_out         = main_q.pred;
  assign local_index_out  = main_q.local_index;
  assign global_index_out = main_q.global_index;

endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid -- scoreboard bench for if_id_skid.
// A recorder pushes every accepted fetch word into a queue; a separate
// monitor compares the DUT head, occupancy, out_valid and in_ready against
// that queue on every falling edge and pops on each decode handshake.
module tb_if_id_skid;
  localparam int unsigned W  = 16;
  localparam int unsigned LS = 8;
  localparam int unsigned GS = 6;
  localparam int unsigned PW = 2 * W + 3 + LS + GS;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  pc_in;
  logic [W-1:0]  ir_in;
  logic          br_pr_in;
  logic [1:0]    pred_in;
  logic [LS-1:0] local_index_in;
  logic [GS-1:0] global_index_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  pc_out;
  logic [W-1:0]  ir_out;
  logic          br_pr_out;
  logic [1:0]    pred_out;
  logic [LS-1:0] local_index_out;
  logic [GS-1:0] global_index_out;
  logic [1:0]    occupancy;

  logic [PW-1:0] in_word, out_word;
  logic [PW-1:0] q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_skid #(.W(W), .LS(LS), .GS(GS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .ir_in(ir_in), .br_pr_in(br_pr_in), .pred_in(pred_in),
    .local_index_in(local_index_in), .global_index_in(global_index_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .ir_out(ir_out), .br_pr_out(br_pr_out), .pred_out(pred_out),
    .local_index_out(local_index_out), .global_index_out(global_index_out),
    .occupancy(occupancy)
  );

  assign in_word  = {pc_in, ir_in, br_pr_in, pred_in, local_index_in, global_index_in};
  assign out_word = {pc_out, ir_out, br_pr_out, pred_out, local_index_out, global_index_out};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Recorder: sees pre-edge values, so it knows exactly what the edge accepts.
  always @(posedge clk) begin
    if (reset) begin
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(in_word);
    end
  end

  // Monitor: queue holds exactly what the DUT should be holding right now.
  always @(negedge clk) begin
    if (reset) begin
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (out_valid && q.size() != 0) begin
        chk("head_word", 64'(out_word), 64'(q[0]));
        if (out_ready && !flush) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [W-1:0] pc, input logic [W-1:0] ir, input logic br,
                          input logic [1:0] pred, input logic [LS-1:0] li, input logic [GS-1:0] gi);
    in_valid        = 1'b1;
    pc_in           = pc;
    ir_in           = ir;
    br_pr_in        = br;
    pred_in         = pred;
    local_index_in  = li;
    global_index_in = gi;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; ir_in = '0; br_pr_in = 1'b0; pred_in = '0;
    local_index_in = '0; global_index_in = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_payload", 64'(out_word), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Streaming: each word visible one cycle after its push.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_word(W'(2 * i), W'(16'h1000 + i), 1'b0, 2'b01, LS'(i), GS'(i));
      tick();
      chk("stream_pc", 64'(pc_out), 64'(2 * i));
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Stall: second word lands in the skid entry.
    out_ready = 1'b0;
    set_word(16'h0010, 16'h1234, 1'b0, 2'b11, 8'h01, 6'h01);
    tick();
    chk("stall_pc_a", 64'(pc_out), 64'h10);
    set_word(16'h0012, 16'h5678, 1'b0, 2'b00, 8'h02, 6'h02);
    tick();
    in_valid = 1'b0;
    chk("stall_occ", 64'(occupancy), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_pc_hold", 64'(pc_out), 64'h10);
    chk("stall_ir_hold", 64'(ir_out), 64'h1234);
    chk("stall_pred_hold", 64'(pred_out), 64'd3);
    tick();
    chk("stall_pc_hold2", 64'(pc_out), 64'h10);
    out_ready = 1'b1;
    tick();
    chk("unstall_pc_b", 64'(pc_out), 64'h12);
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("unstall_empty", 64'(occupancy), 64'd0);
    out_ready = 1'b0;

    // Metadata integrity through the skid entry.
    set_word(16'h0020, 16'h2222, 1'b0, 2'b00, 8'h00, 6'h00);
    tick();
    set_word(16'h0022, 16'h3333, 1'b1, 2'b01, 8'hA5, 6'h2A);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("meta_pc", 64'(pc_out), 64'h22);
    chk("meta_local", 64'(local_index_out), 64'hA5);
    chk("meta_global", 64'(global_index_out), 64'h2A);
    chk("meta_br", 64'(br_pr_out), 64'd1);
    tick();
    out_ready = 1'b0;

    // Flush from FULL with a competing push and pop.
    set_word(16'h0030, 16'h4444, 1'b0, 2'b10, 8'h03, 6'h03);
    tick();
    set_word(16'h0032, 16'h5555, 1'b0, 2'b10, 8'h04, 6'h04);
    tick();
    set_word(16'h0040, 16'h6666, 1'b1, 2'b11, 8'h05, 6'h05);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_ir", 64'(ir_out), 64'd0);
    chk("flush_pc", 64'(pc_out), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush_no_0x40", 64'(out_valid), 64'd0);

    // Flush from ONE while in_ready is high: the input word is still dropped.
    out_ready = 1'b0;
    set_word(16'h0048, 16'h7777, 1'b0, 2'b01, 8'h06, 6'h06);
    tick();
    set_word(16'h0050, 16'h8888, 1'b0, 2'b01, 8'h07, 6'h07);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_occ", 64'(occupancy), 64'd0);
    chk("flush1_pc", 64'(pc_out), 64'd0);

    // Asynchronous reset while FULL.
    set_word(16'h0060, 16'h9999, 1'b1, 2'b10, 8'h08, 6'h08);
    tick();
    set_word(16'h0062, 16'hAAAA, 1'b1, 2'b10, 8'h09, 6'h09);
    tick();
    in_valid = 1'b0;
    chk("pre_reset_occ", 64'(occupancy), 64'd2);
    #2 reset = 1'b0;
    q.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_pc", 64'(pc_out), 64'd0);
    chk("arst_ir", 64'(ir_out), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Random valid/ready traffic with occasional flushes.
    for (int n = 0; n < 3000; n++) begin
      set_word(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom),
               LS'($urandom), GS'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_occ", 64'(occupancy), 64'd0);
    chk("drain_queue", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
